mac_rx_frame_buf: RTL and testbench



---
 rtl/mac_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 40 ++++
 rtl/mac_rx_frame_buf.sv | 191 +++++++++++++++++++
 tb/tb_mac_rx_frame_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC receive path: FSM encodings and default sizes.
package mac_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int LQ_W_DEF   = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LOAD = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, used as the frame length queue.
module sync_fifo #(
    parameter int WIDTH   = 12,
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic               empty,
    output logic [DEPTH_W:0]   count
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];
    logic [DEPTH_W:0] wp;
    logic [DEPTH_W:0] rp;
    logic             full;

    assign count = wp - rp;
    assign empty = (count == '0);
    assign full  = count[DEPTH_W];
    assign dout  = mem[rp[DEPTH_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[DEPTH_W-1:0]] <= din;
    end

endmodule

// File: rtl/mac_rx_frame_buf.sv
// Store-and-forward receive buffer: only frames that end clean are replayed downstream.
//   state   | meaning
//   W_IDLE  | waiting for sof; wr_ptr == wr_base
//   W_FRAME | writing bytes of the current frame
//   W_DROP  | buffer filled mid-frame; discarding until eof or sof
//   R_IDLE  | waiting for a committed frame length
//   R_LOAD  | RAM read of the first byte
//   R_DATA  | streaming bytes, rcnt counts down to the last one
module mac_rx_frame_buf
    import mac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LQ_W   = LQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sof,
    input  logic              rx_eof,
    input  logic              rx_crc_good,
    input  logic              rx_fr_err,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  frm_ok_cnt,
    output logic [CNT_W-1:0]  frm_drop_cnt,
    output logic              buf_full
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]      mem [2**ADDR_W];
    logic [7:0]      ram_q;
    logic [PW-1:0]   wr_ptr, wr_ptr_n, wr_base, wr_base_n, len, len_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n, rcnt, rcnt_n;
    logic [ADDR_W-1:0] waddr;
    wr_state_t       w_state, w_next;
    rd_state_t       r_state, r_next;
    logic            we, eof_wr, ok_inc, lq_push, lq_pop, lq_empty, lq_full;
    logic [1:0]      drop_inc;
    logic            full_ptr, full_base, xfer;
    logic [PW-1:0]   lq_dout;
    logic [LQ_W:0]   lq_count;
    logic [LQ_W+1:0] lq_pend;

    assign full_ptr  = ((wr_ptr - rd_ptr) == DEPTH);
    assign full_base = ((wr_base - rd_ptr) == DEPTH);
    assign buf_full  = full_ptr;

    // The frame being streamed has already left the queue but is still pending.
    assign lq_pend = (LQ_W+2)'(lq_count) + (LQ_W+2)'(r_state != R_IDLE);
    assign lq_full = (lq_pend >= (LQ_W+2)'(2**LQ_W));

    always_comb begin
        w_next    = w_state;
        wr_ptr_n  = wr_ptr;
        wr_base_n = wr_base;
        len_n     = len;
        we        = 1'b0;
        waddr     = wr_ptr[ADDR_W-1:0];
        eof_wr    = 1'b0;
        ok_inc    = 1'b0;
        drop_inc  = 2'd0;
        lq_push   = 1'b0;
        if (rx_valid) begin
            if (rx_sof) begin
                if (w_state != W_IDLE) drop_inc = 2'd1;
                wr_ptr_n = wr_base;
                if (full_base) begin
                    if (rx_eof) begin
                        drop_inc = drop_inc + 2'd1;
                        w_next   = W_IDLE;
                    end else begin
                        w_next = W_DROP;
                    end
                end else begin
                    we       = 1'b1;
                    waddr    = wr_base[ADDR_W-1:0];
                    len_n    = PW'(1);
                    wr_ptr_n = wr_base + 1'b1;
                    eof_wr   = rx_eof;
                    w_next   = rx_eof ? W_IDLE : W_FRAME;
                end
            end else if (w_state == W_FRAME) begin
                if (full_ptr) begin
                    if (rx_eof) begin
                        wr_ptr_n = wr_base;
                        drop_inc = 2'd1;
                        w_next   = W_IDLE;
                    end else begin
                        w_next = W_DROP;
                    end
                end else begin
                    we       = 1'b1;
                    len_n    = len + 1'b1;
                    wr_ptr_n = wr_ptr + 1'b1;
                    eof_wr   = rx_eof;
                    w_next   = rx_eof ? W_IDLE : W_FRAME;
                end
            end else if (w_state == W_DROP && rx_eof) begin
                wr_ptr_n = wr_base;
                drop_inc = 2'd1;
                w_next   = W_IDLE;
            end
        end
        if (eof_wr) begin
            if (rx_crc_good && !rx_fr_err && !lq_full) begin
                wr_base_n = wr_ptr_n;
                lq_push   = 1'b1;
                ok_inc    = 1'b1;
            end else begin
                wr_ptr_n = wr_base;
                drop_inc = drop_inc + 2'd1;
            end
        end
    end

    assign xfer = (r_state == R_DATA) && m_tready;

    always_comb begin
        r_next   = r_state;
        rcnt_n   = rcnt;
        lq_pop   = 1'b0;
        rd_ptr_n = rd_ptr + PW'(xfer);
        case (r_state)
            R_IDLE: if (!lq_empty) begin
                lq_pop = 1'b1;
                rcnt_n = lq_dout;
                r_next = R_LOAD;
            end
            R_LOAD: r_next = R_DATA;
            R_DATA: if (xfer) begin
                rcnt_n = rcnt - 1'b1;
                if (rcnt == PW'(1)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            wr_ptr       <= '0;
            wr_base      <= '0;
            len          <= '0;
            rd_ptr       <= '0;
            rcnt         <= '0;
            frm_ok_cnt   <= '0;
            frm_drop_cnt <= '0;
        end else begin
            w_state      <= w_next;
            r_state      <= r_next;
            wr_ptr       <= wr_ptr_n;
            wr_base      <= wr_base_n;
            len          <= len_n;
            rd_ptr       <= rd_ptr_n;
            rcnt         <= rcnt_n;
            frm_ok_cnt   <= frm_ok_cnt + CNT_W'(ok_inc);
            frm_drop_cnt <= frm_drop_cnt + CNT_W'(drop_inc);
        end
    end

    // Reading at the next read address keeps ram_q equal to mem[rd_ptr], one byte per cycle.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= rx_data;
        ram_q <= mem[rd_ptr_n[ADDR_W-1:0]];
    end

    assign m_tvalid = (r_state == R_DATA);
    assign m_tlast  = m_tvalid && (rcnt == PW'(1));
    assign m_tdata  = m_tvalid ? ram_q : 8'h00;

    sync_fifo #(
        .WIDTH   (PW),
        .DEPTH_W (LQ_W)
    ) u_len_q (
        .clk   (clk),
        .rst   (rst),
        .push  (lq_push),
        .din   (len_n),
        .pop   (lq_pop),
        .dout  (lq_dout),
        .empty (lq_empty),
        .count (lq_count)
    );

endmodule

// File: tb/tb_mac_rx_frame_buf.sv
// Directed bench for mac_rx_frame_buf: commit/drop paths, overflow, length-queue limit, reset.
module tb_mac_rx_frame_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_crc_good, rx_fr_err;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [15:0] frm_ok_cnt, frm_drop_cnt;
    logic        buf_full;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];

    always #5 clk = ~clk;

    mac_rx_frame_buf dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_crc_good  (rx_crc_good),
        .rx_fr_err    (rx_fr_err),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .frm_ok_cnt   (frm_ok_cnt),
        .frm_drop_cnt (frm_drop_cnt),
        .buf_full     (buf_full)
    );

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic sof, input logic eof,
                        input logic crc, input logic err);
        @(posedge clk); #1;
        rx_valid    = 1'b1;
        rx_data     = d;
        rx_sof      = sof;
        rx_eof      = eof;
        rx_crc_good = crc;
        rx_fr_err   = err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
            rx_eof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] seed, input logic crc,
                              input logic err, input logic term, input logic keep);
        for (int i = 0; i < len; i++) begin
            beat(seed + 8'(i), i == 0, term && (i == len - 1), crc, err);
            if (keep) begin
                exp_d.push_back(seed + 8'(i));
                exp_l.push_back(i == len - 1);
            end
        end
        idle(1);
    endtask

    task automatic drain(input string tag);
        int budget = 0;
        while (got_d.size() < exp_d.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk({tag, "_data"}, {24'h0, got_d[i]}, {24'h0, exp_d[i]});
            chk({tag, "_last"}, {31'h0, got_l[i]}, {31'h0, exp_l[i]});
        end
        got_d.delete(); got_l.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, {31'h0, m_tvalid}, 32'h0);
        chk({tag, "_tlast"},  {31'h0, m_tlast},  32'h0);
        chk({tag, "_tdata"},  {24'h0, m_tdata},  32'h0);
        chk({tag, "_ok"},     {16'h0, frm_ok_cnt},   32'h0);
        chk({tag, "_drop"},   {16'h0, frm_drop_cnt}, 32'h0);
        chk({tag, "_full"},   {31'h0, buf_full}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        rx_crc_good = 1'b0; rx_fr_err = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // single good frame
        send_frame(64, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("t1");
        chk("t1_ok",   {16'h0, frm_ok_cnt},   32'd1);
        chk("t1_drop", {16'h0, frm_drop_cnt}, 32'd0);

        // bad crc then good frame
        send_frame(64, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(60, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("t2");
        chk("t2_ok",   {16'h0, frm_ok_cnt},   32'd2);
        chk("t2_drop", {16'h0, frm_drop_cnt}, 32'd1);

        // overflow with consumer stalled
        @(posedge clk); #1 m_tready = 1'b0;
        send_frame(1500, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            beat(8'h20 + 8'(i), i == 0, i == 1499, 1'b1, 1'b0);
            if (i == 600) begin
                @(negedge clk);
                chk("t3_full", {31'h0, buf_full}, 32'd1);
            end
        end
        idle(3);
        @(negedge clk);
        chk("t3_full_clr", {31'h0, buf_full}, 32'd0);
        chk("t3_drop2",    {16'h0, frm_drop_cnt}, 32'd2);
        chk("t3_hold_v",   {31'h0, m_tvalid}, 32'd1);
        chk("t3_hold_d",   {24'h0, m_tdata},  32'h00);
        chk("t3_hold_l",   {31'h0, m_tlast},  32'd0);
        send_frame(1500, 8'h60, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("t3_ok",   {16'h0, frm_ok_cnt},   32'd3);
        chk("t3_drop", {16'h0, frm_drop_cnt}, 32'd3);
        @(posedge clk); #1 m_tready = 1'b1;
        drain("t3");

        // sof inside an unterminated frame
        send_frame(29, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(40, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("t4");
        chk("t4_ok",   {16'h0, frm_ok_cnt},   32'd4);
        chk("t4_drop", {16'h0, frm_drop_cnt}, 32'd4);

        // length queue limit with single-byte frames
        @(posedge clk); #1 m_tready = 1'b0;
        for (int k = 0; k < 17; k++)
            send_frame(1, 8'hA0 + 8'(k), 1'b1, 1'b0, 1'b1, k < 16);
        idle(2);
        @(negedge clk);
        chk("t5_ok",     {16'h0, frm_ok_cnt},   32'd20);
        chk("t5_drop",   {16'h0, frm_drop_cnt}, 32'd5);
        chk("t5_hold_d", {24'h0, m_tdata},  32'hA0);
        chk("t5_hold_l", {31'h0, m_tlast},  32'd1);
        @(posedge clk); #1 m_tready = 1'b1;
        drain("t5");

        // reset mid-frame, then mid-output
        for (int i = 0; i < 20; i++) beat(8'h11 + 8'(i), i == 0, 1'b0, 1'b1, 1'b0);
        pulse_rst();
        chk_zero("t6_rst1");
        send_frame(50, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 300 && got_d.size() < 10; b++) @(negedge clk);
        chk("t6_mid", {31'h0, m_tvalid}, 32'd1);
        pulse_rst();
        chk_zero("t6_rst2");
        got_d.delete(); got_l.delete();
        send_frame(45, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("t6");
        chk("t6_ok",   {16'h0, frm_ok_cnt},   32'd1);
        chk("t6_drop", {16'h0, frm_drop_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
